// File: rtl/mux_scan_pkg.sv
// Shared types for the 4-channel mux scanner: channel select, dwell counter and FSM states.
package mux_scan_pkg;
  localparam int NUM_CH = 4;

  typedef logic [1:0] sel_t;
  typedef logic [7:0] dwell_cnt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DWELL_ST = 2'd1,
    HOLD     = 2'd2
  } scan_state_t;
endpackage

// File: rtl/mux_scan_next_ch.sv
// Priority finder: lowest enabled channel (first_i=1) or lowest enabled channel strictly above cur_i.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  sel_t              cur_i,
  input  logic              first_i,
  output sel_t              next_o,
  output logic              found_o
);

  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    // Walk downwards so the lowest qualifying channel is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        next_o  = sel_t'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Channel scanner driving mux selects S1/S0 and collecting Y into a 4-bit snapshot.
// Optional MUX_SCAN_CONTINUOUS_EN: restart a new scan directly on each snapshot handshake.
module mux4_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  chan_mask,
  input  logic        Y,
  output logic        S0,
  output logic        S1,
  output logic        busy,
  output logic [3:0]  snap_data,
  output logic        snap_valid,
  input  logic        snap_ready,
  output scan_state_t dbg_state_o
);

  localparam dwell_cnt_t CNT_LAST = dwell_cnt_t'(DWELL - 1);

  scan_state_t state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  work_q, work_d;
  logic [3:0]  snap_data_q, snap_data_d;
  logic        snap_valid_q, snap_valid_d;
  logic        busy_q, busy_d;
  sel_t        ch_q, ch_d;
  dwell_cnt_t  cnt_q, cnt_d;

  sel_t        first_ch, nxt_ch;
  logic        first_found, nxt_found;
  logic [3:0]  work_merged;

  mux_scan_next_ch u_first (
    .mask_i  (chan_mask),
    .cur_i   (2'b00),
    .first_i (1'b1),
    .next_o  (first_ch),
    .found_o (first_found)
  );

  mux_scan_next_ch u_next (
    .mask_i  (mask_q),
    .cur_i   (ch_q),
    .first_i (1'b0),
    .next_o  (nxt_ch),
    .found_o (nxt_found)
  );

  always_comb begin
    work_merged       = work_q;
    work_merged[ch_q] = Y;
  end

  // Output handshake: a snapshot transfers on any rising edge where snap_valid && snap_ready;
  // snap_valid/snap_data are held stable until then and snap_ready alone has no effect.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    work_d       = work_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    busy_d       = busy_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && first_found) begin
          mask_d  = chan_mask;
          work_d  = '0;
          ch_d    = first_ch;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = DWELL_ST;
        end
      end
      DWELL_ST: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          work_d = work_merged;
          if (nxt_found) begin
            ch_d = nxt_ch;
          end else begin
            snap_data_d  = work_merged;
            snap_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (snap_valid_q && snap_ready) begin
          snap_valid_d = 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
          if (first_found) begin
            mask_d  = chan_mask;
            work_d  = '0;
            ch_d    = first_ch;
            cnt_d   = '0;
            state_d = DWELL_ST;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      work_q       <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ch_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      work_q       <= work_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      busy_q       <= busy_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
    end
  end

  assign S1          = ch_q[1];
  assign S0          = ch_q[0];
  assign busy        = busy_q;
  assign snap_data   = snap_data_q;
  assign snap_valid  = snap_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl with a behavioural 4:1 mux closing the Y feedback loop.
module tb_mux4_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int DWELL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  chan_mask;
  logic [3:0]  ch_data;
  logic        Y;
  logic        S0, S1, busy, snap_valid, snap_ready;
  logic [3:0]  snap_data;
  scan_state_t dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] data;
    logic [3:0] exp_snap;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  assign Y = ch_data[{S1, S0}];

  mux4_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .chan_mask   (chan_mask),
    .Y           (Y),
    .S0          (S0),
    .S1          (S1),
    .busy        (busy),
    .snap_data   (snap_data),
    .snap_valid  (snap_valid),
    .snap_ready  (snap_ready),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Starts a scan at a falling edge and checks select sequence, latency, snapshot and handshake.
  task automatic run_scan(input logic [3:0] mask, input logic [3:0] data,
                          input logic [3:0] exp_snap, input int hold_cycles);
    int n;
    logic [1:0] last_sel;
    logic [1:0] exp_sel;
    ch_data    = data;
    chan_mask  = mask;
    snap_ready = 1'b0;
    start      = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 4; c++)
      if (mask[c]) for (int d = 0; d < DWELL; d++) exp_q.push_back(2'(c));
    n = exp_q.size();
    last_sel = exp_q[n-1];
    @(negedge clk);
    start     = 1'b0;
    chan_mask = 4'($urandom_range(0, 15));
    for (int j = 1; j <= n; j++) begin
      exp_sel = exp_q.pop_front();
      check("scan_sel", {6'd0, S1, S0}, {6'd0, exp_sel});
      check("scan_valid_low", snap_valid, 0);
      check("scan_busy", busy, 1);
      @(negedge clk);
    end
    check("valid_latency", snap_valid, 1);
    check("snap_data", snap_data, exp_snap);
    check("hold_busy", busy, 1);
    check("hold_sel", {6'd0, S1, S0}, {6'd0, last_sel});
    for (int h = 0; h < hold_cycles; h++) begin
      ch_data[0] = ~ch_data[0];
      start      = 1'b1;
      chan_mask  = 4'b1111;
      @(negedge clk);
      check("hold_valid", snap_valid, 1);
      check("hold_data_stable", snap_data, exp_snap);
      check("hold_sel_stable", {6'd0, S1, S0}, {6'd0, last_sel});
      check("hold_state", 8'(dbg_state), 8'(HOLD));
    end
    start      = 1'b0;
    chan_mask  = 4'b0000;
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    check("hs_valid_clear", snap_valid, 0);
    check("hs_busy_clear", busy, 0);
    check("hs_state_idle", 8'(dbg_state), 8'(IDLE));
    check("idle_data_kept", snap_data, exp_snap);
    @(negedge clk);
    check("idle_stays", 8'(dbg_state), 8'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{mask: 4'b1111, data: 4'b1101, exp_snap: 4'b1101};
    vecs[1] = '{mask: 4'b1010, data: 4'b1011, exp_snap: 4'b1010};
    vecs[2] = '{mask: 4'b0100, data: 4'b0100, exp_snap: 4'b0100};
    vecs[3] = '{mask: 4'b1001, data: 4'b0110, exp_snap: 4'b0000};
    vecs[4] = '{mask: 4'b0111, data: 4'b1111, exp_snap: 4'b0111};
    vecs[5] = '{mask: 4'b1000, data: 4'b1000, exp_snap: 4'b1000};

    rst        = 1'b1;
    start      = 1'b0;
    chan_mask  = 4'b0000;
    ch_data    = 4'b0000;
    snap_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", {6'd0, S1, S0}, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", snap_valid, 0);
    check("rst_data", snap_data, 0);
    check("rst_state", 8'(dbg_state), 8'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Empty mask: start must be ignored.
    chan_mask = 4'b0000;
    start     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_mask_busy", busy, 0);
      check("zero_mask_state", 8'(dbg_state), 8'(IDLE));
      check("zero_mask_sel", {6'd0, S1, S0}, 0);
    end
    start = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_scan(vecs[v].mask, vecs[v].data, vecs[v].exp_snap, 0);

    // Back-pressure: hold for 5 cycles while A toggles and start is pulsed.
    run_scan(4'b1111, 4'b1101, 4'b1101, 5);

    // Asynchronous reset during channel 2 of a full scan.
    ch_data   = 4'b1111;
    chan_mask = 4'b1111;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_sel", {6'd0, S1, S0}, 8'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel", {6'd0, S1, S0}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", snap_valid, 0);
    check("async_rst_data", snap_data, 0);
    check("async_rst_state", 8'(dbg_state), 8'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", snap_valid, 0);
    end
    run_scan(4'b0110, 4'b0010, 4'b0010, 0);

`ifdef MUX_SCAN_CONTINUOUS_EN
    begin
      int budget;
      ch_data    = 4'b0001;
      chan_mask  = 4'b0001;
      snap_ready = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      budget = 0;
      while (!snap_valid && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check("cont_first_valid", snap_valid, 1);
      for (int p = 0; p < 3; p++) begin
        check("cont_data", snap_data, 4'b0001);
        for (int i = 0; i < DWELL; i++) begin
          @(negedge clk);
          check("cont_gap_valid", snap_valid, 0);
          check("cont_busy", busy, 1);
        end
        @(negedge clk);
        check("cont_period_valid", snap_valid, 1);
      end
      chan_mask = 4'b0000;
      @(negedge clk);
      snap_ready = 1'b0;
      check("cont_stop_valid", snap_valid, 0);
      check("cont_stop_busy", busy, 0);
      check("cont_stop_state", 8'(dbg_state), 8'(IDLE));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Sequential channel scanner that sits directly upstream of the 4-to-1 mux and drives its select lines S1/S0.
- Steps through the enabled channels (0=A, 1=B, 2=C, 3=D) in ascending order and waits DWELL cycles on each.
- Samples the mux output Y for each channel and assembles a 4-bit snapshot.
- Presents the snapshot on a valid/ready output handshake.

Parameters:
DWELL, 2, cycles the select is held per channel before Y is sampled; legal range 1..255.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  scan request; one-cycle pulse or level
chan_mask  input  4  enabled channels; bit i = channel i
Y  input  1  mux output fed back from the mux
S0  output  1  mux select LSB
S1  output  1  mux select MSB
busy  output  1  high from the cycle after start is accepted until the handshake completes
snap_data  output  4  bit i = Y sampled on channel i; 0 for masked channels
snap_valid  output  1  snapshot available
snap_ready  input  1  downstream accepts snapshot

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: S1=0, S0=0, busy=0, snap_data=4'b0000, snap_valid=0. State goes to IDLE, dwell counter=0, working register=0.
- States: IDLE, DWELL_ST, HOLD.
- IDLE:
  - start=1 with chan_mask!=0: latch mask, clear working register, set ch to the lowest set bit, clear counter, busy<=1, go to DWELL_ST.
  - start=1 with chan_mask==0: ignored; stay in IDLE.
- DWELL_ST:
  - {S1,S0}=ch, registered and updated on the same edge ch changes.
  - Counter increments each cycle.
  - When counter==DWELL-1: work[ch]<=Y on that edge, counter<=0.
  - If a higher enabled channel exists, ch<=that channel and stay in DWELL_ST.
  - Otherwise snap_data<=work with the current sample merged, snap_valid<=1, go to HOLD.
- HOLD:
  - snap_data and snap_valid are stable until snap_valid&&snap_ready.
  - On handshake: snap_valid<=0, busy<=0, go to IDLE.
  - snap_data retains its last value in IDLE.
- Latency: with k enabled channels, snap_valid rises k*DWELL cycles after the edge that accepts start.
- Timing contract with the mux: Y is combinational from S1/S0. Y sampled at counter==DWELL-1 reflects the select driven since the first DWELL cycle.
- Select does not change in HOLD or IDLE; it keeps the last scanned channel.
- start while busy: ignored. Mask changes while busy: ignored (latched copy is used).
- snap_ready while snap_valid=0: ignored.
- rst asserted mid-scan: immediate return to reset values. The partial snapshot is discarded and no snap_valid is produced.
- Width rules:
  - Counter is 8 bits.
  - Next-channel search considers only latched-mask bits strictly above ch. No wrap-around within one scan.

Optional Feature:
MUX_SCAN_CONTINUOUS_EN
- Defined: on the HOLD handshake edge, if the current chan_mask!=0, relatch the mask and restart at its lowest set bit directly into DWELL_ST. busy stays 1 and there are no idle cycles. If chan_mask==0, go to IDLE.
- Undefined: behaviour exactly as above; each snapshot requires a new start.

Decomposition:
- Package mux_scan_pkg:
  - NUM_CH=4
  - typedef sel_t (logic [1:0])
  - typedef enum scan_state_t {IDLE, DWELL_ST, HOLD}
  - typedef dwell_cnt_t (logic [7:0])
- Sub-module mux_scan_next_ch: combinational priority finder. Inputs: mask[3:0], cur sel_t, first flag. Outputs: next sel_t and found. It is used for both the first-channel and next-channel search.

Test Plan:
1. DWELL=2, mask=4'b1111, A=1 B=0 C=1 D=1, start pulse -> select sequence 00,00,01,01,10,10,11,11; snap_data=4'b1101; snap_valid 8 cycles after start accepted; busy=1 throughout.
2. DWELL=2, mask=4'b1010, A=1 B=1 C=0 D=1 -> selects 01 for 2 cycles then 11 for 2 cycles; snap_data=4'b1010; valid after 4 cycles.
3. snap_ready=0 for 5 cycles after valid, A toggling -> snap_data and snap_valid stable; clears one cycle after snap_ready=1; busy=0; start during HOLD ignored.
4. mask=4'b0000 with start=1 -> stays in IDLE; busy=0; select 00.
5. rst=1 asynchronously mid-scan (during channel 2) -> outputs immediately at reset values; no snap_valid after release; next start scans normally.
6. MUX_SCAN_CONTINUOUS_EN defined, mask=4'b0001, snap_ready=1 -> snap_valid pulses every DWELL+1 cycles; busy constantly 1; mask set to 0 -> returns to IDLE after the next handshake.
